square_seq: RTL and testbench
=============================

SQUARE_SEQ -- requirements
Module: square_seq

Interface
REQ-001 Parameter WIDTH, default 8, is the signed input operand width (WIDTH >= 2).
REQ-002 Parameter OUT_WIDTH, default 2*WIDTH, is the unsigned result width (OUT_WIDTH <= 2*WIDTH).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port in, input, WIDTH bits, signed two's-complement operand.
REQ-006 Port in_valid, input, 1 bit: operand present.
REQ-007 Port in_ready, output, 1 bit: block can accept an operand.
REQ-008 Port out, output, OUT_WIDTH bits, unsigned square of the accepted operand.
REQ-009 Port out_valid, output, 1 bit: out holds a finished result.
REQ-010 Port out_ready, input, 1 bit: consumer takes the result.
REQ-011 Port ovf, output, 1 bit: present only when SQUARE_SEQ_SAT_EN is defined; result was clipped.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 Accept: on a rising edge in IDLE with in_valid = 1, the block registers |in| as a WIDTH-bit unsigned magnitude, clears the accumulator and bit counter, and enters BUSY.
REQ-014 Magnitude rule: in = -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1) without overflow.
REQ-015 BUSY: each edge processes one multiplier bit i (i = 0..WIDTH-1): acc += (mag << i) if mag[i] = 1; acc is 2*WIDTH bits.
REQ-016 After exactly WIDTH BUSY edges, the state is DONE; out_valid rises WIDTH edges after the accepting edge.
REQ-017 DONE: out and out_valid hold stable until an edge with out_ready = 1, after which the state is IDLE.
REQ-018 No same-cycle re-accept: in_ready is low in DONE; peak throughput is one result per WIDTH+2 cycles.
REQ-019 in and in_valid are ignored in BUSY and DONE; out_ready is ignored outside DONE.
REQ-020 out is registered; its value is only defined when out_valid = 1; it does not change while out_valid = 1.
REQ-021 Without saturation, out = acc[OUT_WIDTH-1:0] (modulo 2^OUT_WIDTH wrap).

Reset
REQ-022 While rst = 1, state = IDLE, acc = 0, counter = 0, out = 0, out_valid = 0, in_ready = 1, ovf = 0, regardless of clk.
REQ-023 Reset asserted in BUSY or DONE discards the operation in progress; no result is emitted for it.
REQ-024 On the first edge after rst deasserts, an operand with in_valid = 1 is accepted normally.

Configuration
REQ-025 Macro SQUARE_SEQ_SAT_EN, when defined, adds port ovf and saturating output: if acc >= 2^OUT_WIDTH, out = 2^OUT_WIDTH - 1 and ovf = 1; otherwise out = acc and ovf = 0.
REQ-026 ovf is valid and stable under the same conditions as out (REQ-020).
REQ-027 When SQUARE_SEQ_SAT_EN is undefined, port ovf does not exist and REQ-021 wrap applies.
REQ-028 When OUT_WIDTH = 2*WIDTH, the results are identical with or without the macro, and ovf is always 0.

Verification
REQ-029 Exhaustive: WIDTH=4, OUT_WIDTH=8, in = -8..7 with out_ready = 1 -> out = i*i (e.g. -8 -> 64, 7 -> 49, 0 -> 0), out_valid 4 edges after accept.
REQ-030 Backpressure: WIDTH=4, in=-5, out_ready = 0 for 10 cycles -> out_valid stays 1, out stays 25, in_ready stays 0; raise out_ready -> IDLE next edge.
REQ-031 Reset mid-operation: WIDTH=8, in=-128 accepted, rst pulsed after 3 BUSY edges -> out_valid = 0, in_ready = 1; next in=127 -> out = 16129.
REQ-032 Saturation, WIDTH=4, OUT_WIDTH=6: in=-8 -> with macro out=63, ovf=1; without macro out=0; in=7 -> out=49 (ovf=0) in both builds.
REQ-033 Ignored inputs: toggle in/in_valid during BUSY with in=3 accepted -> out = 9, exactly one out_valid pulse-window.

Source files
------------

// File: rtl/square_seq.sv
// Sequential shift-and-add squarer: one multiplier bit per clock, WIDTH cycles per result.
// Define SQUARE_SEQ_SAT_EN to saturate the result to OUT_WIDTH bits and expose the ovf flag.
module square_seq #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef SQUARE_SEQ_SAT_EN
  output logic                 ovf,
`endif
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and out holds until taken.
  state_t          state, state_nxt;
  logic [WIDTH-1:0] mag, mag_sh;
  logic [AW-1:0]    acc, acc_nxt, partial;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [OUT_WIDTH-1:0] res;
`ifdef SQUARE_SEQ_SAT_EN
  logic             res_ovf;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    mag_sh  = mag >> cnt;
    partial = {{WIDTH{1'b0}}, mag} << cnt;
    acc_nxt = mag_sh[0] ? (acc + partial) : acc;
    last    = (cnt == CW'(WIDTH - 1));
  end

  // Result is taken from acc_nxt so it can be registered on the final BUSY edge.
`ifdef SQUARE_SEQ_SAT_EN
  always_comb begin
    res_ovf = ((acc_nxt >> OUT_WIDTH) != '0);
    res     = res_ovf ? {OUT_WIDTH{1'b1}} : acc_nxt[OUT_WIDTH-1:0];
  end
`else
  always_comb begin
    res = acc_nxt[OUT_WIDTH-1:0];
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
`ifdef SQUARE_SEQ_SAT_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
            mag <= in[WIDTH-1] ? ((~in) + WIDTH'(1)) : in;
            acc <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            out <= res;
`ifdef SQUARE_SEQ_SAT_EN
            ovf <= res_ovf;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_seq.sv
// Bench for square_seq: three instances (4/8, 8/16, 4/6) exercised by scenario tasks
// against a scoreboard queue of expected {ovf, out} values.
module tb_square_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] din[3];
  logic       dv[3];
  logic       ordy[3];

  wire       irdy0, irdy1, irdy2;
  wire       ov0, ov1, ov2;
  wire [7:0] o0;
  wire [15:0] o1;
  wire [5:0] o2;
  wire [1:0] st0, st1, st2;
`ifdef SQUARE_SEQ_SAT_EN
  wire       f0, f1, f2;
`else
  wire       f0 = 1'b0;
  wire       f1 = 1'b0;
  wire       f2 = 1'b0;
`endif

  square_seq #(.WIDTH(4), .OUT_WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .in(din[0][3:0]), .in_valid(dv[0]), .in_ready(irdy0),
    .out(o0), .out_valid(ov0), .out_ready(ordy[0]),
`ifdef SQUARE_SEQ_SAT_EN
    .ovf(f0),
`endif
    .dbg_state(st0));

  square_seq #(.WIDTH(8), .OUT_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .in(din[1]), .in_valid(dv[1]), .in_ready(irdy1),
    .out(o1), .out_valid(ov1), .out_ready(ordy[1]),
`ifdef SQUARE_SEQ_SAT_EN
    .ovf(f1),
`endif
    .dbg_state(st1));

  square_seq #(.WIDTH(4), .OUT_WIDTH(6)) u2 (
    .clk(clk), .rst(rst), .in(din[2][3:0]), .in_valid(dv[2]), .in_ready(irdy2),
    .out(o2), .out_valid(ov2), .out_ready(ordy[2]),
`ifdef SQUARE_SEQ_SAT_EN
    .ovf(f2),
`endif
    .dbg_state(st2));

  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic int get_w(int d);
    return (d == 1) ? 8 : 4;
  endfunction

  function automatic logic [15:0] get_out(int d);
    case (d)
      0:       return 16'(o0);
      1:       return o1;
      default: return 16'(o2);
    endcase
  endfunction

  function automatic logic get_valid(int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_ready(int d);
    case (d)
      0:       return irdy0;
      1:       return irdy1;
      default: return irdy2;
    endcase
  endfunction

  function automatic logic get_ovf(int d);
    case (d)
      0:       return f0;
      1:       return f1;
      default: return f2;
    endcase
  endfunction

  function automatic logic [1:0] get_state(int d);
    case (d)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  // Reference: arithmetic square, then wrap or clip to the instance's output width.
  function automatic logic [16:0] model(int d, int v);
    int     ow  = (d == 0) ? 8 : (d == 1) ? 16 : 6;
    longint sq  = longint'(v) * longint'(v);
    longint lim = longint'(1) << ow;
`ifdef SQUARE_SEQ_SAT_EN
    if (sq >= lim) return {1'b1, 16'(lim - 1)};
    return {1'b0, 16'(sq)};
`else
    return {1'b0, 16'(sq % lim)};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(input int d, input int v, input int stall, input bit toggle);
    int          lat;
    logic [16:0] e;
    logic [15:0] first;
    n_checks++;
    if (get_ready(d) !== 1'b1) $display("FAIL in_ready_before_op d=%0d got=%b want=1", d, get_ready(d));
    else n_pass++;
    din[d] = 8'(v);
    dv[d]  = 1'b1;
    tick();
    dv[d] = 1'b0;
    exp_q.push_back(model(d, v));
    lat = 0;
    while (get_valid(d) !== 1'b1 && lat < 40) begin
      if (toggle) begin
        din[d]  = 8'($urandom_range(0, 255));
        dv[d]   = 1'($urandom_range(0, 1));
        ordy[d] = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    dv[d]   = 1'b0;
    ordy[d] = 1'b0;
    n_checks++;
    if (lat !== get_w(d)) $display("FAIL latency d=%0d v=%0d got=%0d want=%0d", d, v, lat, get_w(d));
    else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
    n_checks++;
    if ({get_ovf(d), get_out(d)} !== e)
      $display("FAIL result d=%0d v=%0d got ovf=%b out=%0d want ovf=%b out=%0d",
               d, v, get_ovf(d), get_out(d), e[16], e[15:0]);
    else n_pass++;
    first = get_out(d);
    repeat (stall) begin
      tick();
      n_checks++;
      if (get_valid(d) !== 1'b1 || get_out(d) !== first || get_ready(d) !== 1'b0)
        $display("FAIL hold d=%0d got valid=%b out=%0d ready=%b want valid=1 out=%0d ready=0",
                 d, get_valid(d), get_out(d), get_ready(d), first);
      else n_pass++;
    end
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
    n_checks++;
    if (get_valid(d) !== 1'b0 || get_ready(d) !== 1'b1)
      $display("FAIL release d=%0d got valid=%b ready=%b want valid=0 ready=1",
               d, get_valid(d), get_ready(d));
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (get_ready(d) !== 1'b1 || get_valid(d) !== 1'b0 || get_out(d) !== 16'd0 ||
          get_ovf(d) !== 1'b0 || get_state(d) !== 2'd0)
        $display("FAIL reset d=%0d got ready=%b valid=%b out=%0d ovf=%b state=%0d want 1/0/0/0/0",
                 d, get_ready(d), get_valid(d), get_out(d), get_ovf(d), get_state(d));
      else n_pass++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exhaustive();
    for (int v = -8; v <= 7; v++) do_op(0, v, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_op(0, -5, 10, 1'b0);
  endtask

  task automatic test_reset_mid();
    din[1] = 8'h80;
    dv[1]  = 1'b1;
    tick();
    dv[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ov1 !== 1'b0 || irdy1 !== 1'b1 || st1 !== 2'd0)
      $display("FAIL reset_mid got valid=%b ready=%b state=%0d want 0/1/0", ov1, irdy1, st1);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 127, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (ov1 !== 1'b0) $display("FAIL no_stale_result cycle=%0d got valid=%b want 0", i, ov1);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_op(2, -8, 0, 1'b0);
    do_op(2, 7, 0, 1'b0);
    do_op(2, -7, 2, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    do_op(0, 3, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (ov0 !== 1'b0 || irdy0 !== 1'b1)
        $display("FAIL single_window cycle=%0d got valid=%b ready=%b want 0/1", i, ov0, irdy0);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++)
      do_op(1, $urandom_range(0, 255) - 128, $urandom_range(0, 3), 1'b0);
    do_op(1, -128, 0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      din[d]  = '0;
      dv[d]   = 1'b0;
      ordy[d] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_exhaustive();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_ignored_inputs();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
